// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the 8080-style LCD bus receiver.
//   - Command codes the receiver decodes (CASET, PASET, RAMWR).
//   - Receiver FSM state encoding.
//   - RGB565 to RGB444 pixel conversion.
package lcd_bus_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CASET_ARG,
        PASET_ARG,
        RAMWR_HI,
        RAMWR_LO,
        SKIP
    } lcd_state_t;

    // Keep the top four bits of each colour channel: R5 -> R4, G6 -> G4, B5 -> B4.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/lcd_wr_sync.sv
// Input synchronizer and write-strobe edge detector for the LCD bus.
// All bus pins pass through SYNC_STAGES flops; a rising edge of the
// synchronized write strobe is registered together with the bus values
// seen in that same cycle.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   db_i       raw data bus
//   wr_i       raw write strobe
//   dc_i       raw data/command select
//   rd_i       raw read strobe
//   lcd_rst_i  raw panel reset (active low)
//   ev_o       one-cycle write event
//   db_o       data byte captured with the event
//   dc_o       data/command flag captured with the event
//   rd_o       read strobe level captured with the event
//   lcd_rst_o  synchronized panel reset (active low)
module lcd_wr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] db_i,
    input  logic       wr_i,
    input  logic       dc_i,
    input  logic       rd_i,
    input  logic       lcd_rst_i,
    output logic       ev_o,
    output logic [7:0] db_o,
    output logic       dc_o,
    output logic       rd_o,
    output logic       lcd_rst_o
);

    // Bundle layout: {lcd_rst, rd, dc, wr, db[7:0]}
    localparam int          SYNC_W   = 12;
    // Write strobe flops reset high so releasing reset with wr idle-high
    // cannot look like a rising edge.
    localparam logic [11:0] SYNC_RST = 12'h100;

    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_W-1:0] sync_s;
    logic              wr_prev_q;
    logic              ev_q;
    logic [7:0]        db_q;
    logic              dc_q;
    logic              rd_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            wr_prev_q <= 1'b1;
            ev_q      <= 1'b0;
            db_q      <= 8'h00;
            dc_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_rst_i, rd_i, dc_i, wr_i, db_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            wr_prev_q <= sync_s[8];
            ev_q      <= sync_s[8] & ~wr_prev_q;
            db_q      <= sync_s[7:0];
            dc_q      <= sync_s[9];
            rd_q      <= sync_s[10];
        end
    end

    assign ev_o      = ev_q;
    assign db_o      = db_q;
    assign dc_o      = dc_q;
    assign rd_o      = rd_q;
    assign lcd_rst_o = sync_s[11];

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiver for an 8080-style LCD controller bus. Decodes CASET/PASET window
// setup and RAMWR pixel streams (RGB565, two bytes per pixel) into pixel
// writes with (x, y) coordinates and RGB444 colour.
// Ports:
//   clk          clock
//   resetN       synchronous active-low reset
//   lcd_db       8-bit parallel data bus
//   lcd_wr       write strobe, data taken on its rising edge
//   lcd_d_c      0 = command, 1 = data
//   lcd_rd       read strobe, must be high during writes
//   lcd_reset    panel reset, active low
//   cmd_valid    pulse per accepted command byte
//   cmd_code     last command byte
//   frame_start  pulse per RAMWR command
//   pxl_valid    pulse per completed pixel
//   pxl_x/pxl_y  pixel coordinates
//   pxl_rgb      RGB444 {R,G,B}
//   err_protocol pulse per protocol violation
module lcd_bus_receiver
    import lcd_bus_pkg::*;
#(
    parameter int LCD_WIDTH   = 320,
    parameter int LCD_HEIGHT  = 240,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  lcd_db,
    input  logic        lcd_wr,
    input  logic        lcd_d_c,
    input  logic        lcd_rd,
    input  logic        lcd_reset,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        frame_start,
    output logic        pxl_valid,
    output logic [9:0]  pxl_x,
    output logic [8:0]  pxl_y,
    output logic [11:0] pxl_rgb,
    output logic        err_protocol
);

    localparam logic [9:0] XE_RST = 10'(LCD_WIDTH - 1);
    localparam logic [8:0] YE_RST = 9'(LCD_HEIGHT - 1);

    logic       ev_s, dc_s, rd_s, lcd_rst_s;
    logic [7:0] db_s;

    lcd_wr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk),
        .rst_ni    (resetN),
        .db_i      (lcd_db),
        .wr_i      (lcd_wr),
        .dc_i      (lcd_d_c),
        .rd_i      (lcd_rd),
        .lcd_rst_i (lcd_reset),
        .ev_o      (ev_s),
        .db_o      (db_s),
        .dc_o      (dc_s),
        .rd_o      (rd_s),
        .lcd_rst_o (lcd_rst_s)
    );

    lcd_state_t  state_q, state_d;
    logic [1:0]  arg_cnt_q, arg_cnt_d;
    logic [23:0] arg_q, arg_d;
    logic [7:0]  hi_q, hi_d;
    logic [9:0]  xs_q, xs_d, xe_q, xe_d, x_q, x_d;
    logic [8:0]  ys_q, ys_d, ye_q, ye_d, y_q, y_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        frame_start_q, frame_start_d;
    logic        pxl_valid_q, pxl_valid_d;
    logic [9:0]  pxl_x_q, pxl_x_d;
    logic [8:0]  pxl_y_q, pxl_y_d;
    logic [11:0] pxl_rgb_q, pxl_rgb_d;
    logic        err_q, err_d;
    logic [15:0] win_lo, win_hi, win_lim;

    always_comb begin
        state_d       = state_q;
        arg_cnt_d     = arg_cnt_q;
        arg_d         = arg_q;
        hi_d          = hi_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        x_d           = x_q;
        y_d           = y_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        frame_start_d = 1'b0;
        pxl_valid_d   = 1'b0;
        pxl_x_d       = pxl_x_q;
        pxl_y_d       = pxl_y_q;
        pxl_rgb_d     = pxl_rgb_q;
        err_d         = 1'b0;
        // Window candidate: first two argument bytes are the start, the
        // buffered third byte plus the current byte form the end.
        win_lo        = arg_q[23:8];
        win_hi        = {arg_q[7:0], db_s};
        win_lim       = (state_q == CASET_ARG) ? 16'(LCD_WIDTH) : 16'(LCD_HEIGHT);

        if (ev_s) begin
            if (!rd_s) begin
                // Bus contention: drop the byte, keep all state.
                err_d = 1'b1;
            end else if (!dc_s) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = db_s;
                arg_cnt_d   = 2'd0;
                // A command interrupting a pixel loses the buffered high byte.
                err_d       = (state_q == RAMWR_LO);
                case (db_s)
                    CMD_CASET: state_d = CASET_ARG;
                    CMD_PASET: state_d = PASET_ARG;
                    CMD_RAMWR: begin
                        state_d       = RAMWR_HI;
                        frame_start_d = 1'b1;
                        x_d           = xs_q;
                        y_d           = ys_q;
                    end
                    default:   state_d = SKIP;
                endcase
            end else begin
                case (state_q)
                    CASET_ARG, PASET_ARG: begin
                        if (arg_cnt_q != 2'd3) begin
                            arg_d     = {arg_q[15:0], db_s};
                            arg_cnt_d = arg_cnt_q + 2'd1;
                        end else begin
                            arg_cnt_d = 2'd0;
                            state_d   = IDLE;
                            if (win_lo > win_hi || win_hi >= win_lim) begin
                                err_d = 1'b1;
                            end else if (state_q == CASET_ARG) begin
                                xs_d = win_lo[9:0];
                                xe_d = win_hi[9:0];
                            end else begin
                                ys_d = win_lo[8:0];
                                ye_d = win_hi[8:0];
                            end
                        end
                    end
                    RAMWR_HI: begin
                        hi_d    = db_s;
                        state_d = RAMWR_LO;
                    end
                    RAMWR_LO: begin
                        pxl_valid_d = 1'b1;
                        pxl_x_d     = x_q;
                        pxl_y_d     = y_q;
                        pxl_rgb_d   = rgb565_to_444({hi_q, db_s});
                        state_d     = RAMWR_HI;
                        if (x_q < xe_q) begin
                            x_d = x_q + 10'd1;
                        end else begin
                            x_d = xs_q;
                            y_d = (y_q == ye_q) ? ys_q : y_q + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Panel reset behaves exactly like resetN for everything after the
    // synchronizer; err_q is cleared too, so no error can escape it.
    always_ff @(posedge clk) begin
        if (!resetN || !lcd_rst_s) begin
            state_q       <= IDLE;
            arg_cnt_q     <= 2'd0;
            arg_q         <= 24'h0;
            hi_q          <= 8'h00;
            xs_q          <= 10'd0;
            xe_q          <= XE_RST;
            ys_q          <= 9'd0;
            ye_q          <= YE_RST;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 8'h00;
            frame_start_q <= 1'b0;
            pxl_valid_q   <= 1'b0;
            pxl_x_q       <= 10'd0;
            pxl_y_q       <= 9'd0;
            pxl_rgb_q     <= 12'h000;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            arg_cnt_q     <= arg_cnt_d;
            arg_q         <= arg_d;
            hi_q          <= hi_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            frame_start_q <= frame_start_d;
            pxl_valid_q   <= pxl_valid_d;
            pxl_x_q       <= pxl_x_d;
            pxl_y_q       <= pxl_y_d;
            pxl_rgb_q     <= pxl_rgb_d;
            err_q         <= err_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_code     = cmd_code_q;
    assign frame_start  = frame_start_q;
    assign pxl_valid    = pxl_valid_q;
    assign pxl_x        = pxl_x_q;
    assign pxl_y        = pxl_y_q;
    assign pxl_rgb      = pxl_rgb_q;
    assign err_protocol = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed vector table, hand-written corner
// sequences and a randomized byte stream checked against a byte-level model.
module tb_lcd_bus_receiver;

    localparam int W    = 320;
    localparam int H    = 240;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  lcd_db = 8'h00;
    logic        lcd_wr = 1'b1;
    logic        lcd_d_c = 1'b1;
    logic        lcd_rd = 1'b1;
    logic        lcd_reset = 1'b1;
    logic        cmd_valid, frame_start, pxl_valid, err_protocol;
    logic [7:0]  cmd_code;
    logic [9:0]  pxl_x;
    logic [8:0]  pxl_y;
    logic [11:0] pxl_rgb;

    lcd_bus_receiver #(.LCD_WIDTH(W), .LCD_HEIGHT(H), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetN(resetN), .lcd_db(lcd_db), .lcd_wr(lcd_wr),
        .lcd_d_c(lcd_d_c), .lcd_rd(lcd_rd), .lcd_reset(lcd_reset),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .frame_start(frame_start),
        .pxl_valid(pxl_valid), .pxl_x(pxl_x), .pxl_y(pxl_y), .pxl_rgb(pxl_rgb),
        .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    int          n_cmd, n_fs, n_err, n_pix;
    int          last_code, last_x, last_y, last_rgb;
    logic [7:0]  got_cmd [$];
    logic [30:0] got_pix [$];

    always @(negedge clk) begin
        if (resetN) begin
            if (cmd_valid)    begin n_cmd++; last_code = cmd_code; got_cmd.push_back(cmd_code); end
            if (frame_start)  n_fs++;
            if (err_protocol) n_err++;
            if (pxl_valid) begin
                n_pix++; last_x = pxl_x; last_y = pxl_y; last_rgb = pxl_rgb;
                got_pix.push_back({pxl_x, pxl_y, pxl_rgb});
            end
        end
    end

    task automatic clr();
        n_cmd = 0; n_fs = 0; n_err = 0; n_pix = 0;
        last_code = -1; last_x = -1; last_y = -1; last_rgb = -1;
        got_cmd.delete(); got_pix.delete();
    endtask

    task automatic wr_byte(input bit dc, input bit rd, input logic [7:0] db);
        @(negedge clk);
        lcd_d_c = dc; lcd_rd = rd; lcd_db = db; lcd_wr = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr = 1'b1;
        repeat (SYNC + 5) @(negedge clk);
        lcd_rd = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
    endtask

    function automatic int m_rgb(input int p);
        int r5, g6, b5;
        r5 = (p / 2048) % 32;
        g6 = (p / 32) % 64;
        b5 = p % 32;
        return (r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2);
    endfunction

    // ---------------- byte-level reference model ----------------
    int          m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_axis, m_hi;
    bit          m_in_ram, m_have_hi;
    int          m_args [$];
    int          exp_err, exp_fs;
    logic [7:0]  exp_cmd [$];
    logic [30:0] exp_pix [$];

    function automatic void model_reset();
        m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1; m_cx = 0; m_cy = 0;
        m_axis = -1; m_in_ram = 0; m_have_hi = 0; m_args.delete();
        exp_err = 0; exp_fs = 0; exp_cmd.delete(); exp_pix.delete();
    endfunction

    function automatic void model_byte(input bit dc, input bit rd, input int db);
        int s, e, lim;
        if (!rd) begin exp_err++; return; end
        if (!dc) begin
            exp_cmd.push_back(8'(db));
            if (m_in_ram && m_have_hi) exp_err++;
            m_args.delete(); m_axis = -1; m_in_ram = 0; m_have_hi = 0;
            if (db == 'h2A) m_axis = 0;
            else if (db == 'h2B) m_axis = 1;
            else if (db == 'h2C) begin m_in_ram = 1; m_cx = m_xs; m_cy = m_ys; exp_fs++; end
            return;
        end
        if (m_axis >= 0) begin
            m_args.push_back(db);
            if (m_args.size() == 4) begin
                s = m_args[0] * 256 + m_args[1];
                e = m_args[2] * 256 + m_args[3];
                lim = (m_axis == 0) ? W : H;
                if (s > e || e >= lim) exp_err++;
                else if (m_axis == 0) begin m_xs = s; m_xe = e; end
                else begin m_ys = s; m_ye = e; end
                m_axis = -1; m_args.delete();
            end
        end else if (m_in_ram) begin
            if (!m_have_hi) begin m_hi = db; m_have_hi = 1; end
            else begin
                exp_pix.push_back({10'(m_cx), 9'(m_cy), 12'(m_rgb(m_hi * 256 + db))});
                m_have_hi = 0;
                if (m_cx < m_xe) m_cx++;
                else begin
                    m_cx = m_xs;
                    m_cy = (m_cy == m_ye) ? m_ys : m_cy + 1;
                end
            end
        end
    endfunction

    task automatic send(input bit dc, input bit rd, input int db);
        model_byte(dc, rd, db);
        wr_byte(dc, rd, 8'(db));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         dc;
        bit         rd;
        logic [7:0] db;
        int         cmd, fs, err, pix;
        int         x, y, rgb;
        int         code;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input bit rst, input bit dc, input bit rd, input logic [7:0] db,
                                input int cmd, input int fs, input int err, input int pix,
                                input int x, input int y, input int rgb);
        vec_t v;
        v.rst = rst; v.dc = dc; v.rd = rd; v.db = db;
        v.cmd = cmd; v.fs = fs; v.err = err; v.pix = pix;
        v.x = x; v.y = y; v.rgb = rgb; v.code = db;
        vecs.push_back(v);
    endfunction

    initial begin
        int n, k, ax, s, e, np;
        bit hit;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_code", cmd_code, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_pxl_valid", pxl_valid, 0);
        chk("rst_pxl_x", pxl_x, 0);
        chk("rst_pxl_y", pxl_y, 0);
        chk("rst_pxl_rgb", pxl_rgb, 0);
        chk("rst_err", err_protocol, 0);
        resetN = 1'b1;
        repeat (SYNC + 4) @(negedge clk);

        // Window setup and wrap
        add(1, 0, 1, 8'h2A, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h0A, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h0D, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 8'h2B, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h05, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h06, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 8'h2C, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            add(0, 1, 1, 8'hF8, 0, 0, 0, 0, 0, 0, 0);
            add(0, 1, 1, 8'h00, 0, 0, 0, 1, 10 + (i % 4), 5 + ((i / 4) % 2), 'hF00);
        end
        // Odd byte then command
        add(0, 0, 1, 8'h2C, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h07, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 0, 0);
        // Read violation
        add(0, 0, 0, 8'h2C, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 8'h55, 0, 0, 1, 0, 0, 0, 0);
        // Bad window, then RAMWR from the default window
        add(1, 0, 1, 8'h2A, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h40, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h41, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 8'h2C, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h12, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 8'h34, 0, 0, 0, 1, 0, 0, m_rgb('h1234));

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            clr();
            wr_byte(vecs[i].dc, vecs[i].rd, vecs[i].db);
            chk($sformatf("v%0d_cmd", i), n_cmd, vecs[i].cmd);
            chk($sformatf("v%0d_fs", i), n_fs, vecs[i].fs);
            chk($sformatf("v%0d_err", i), n_err, vecs[i].err);
            chk($sformatf("v%0d_pix", i), n_pix, vecs[i].pix);
            if (vecs[i].cmd != 0) chk($sformatf("v%0d_code", i), last_code, vecs[i].code);
            if (vecs[i].pix != 0) begin
                chk($sformatf("v%0d_x", i), last_x, vecs[i].x);
                chk($sformatf("v%0d_y", i), last_y, vecs[i].y);
                chk($sformatf("v%0d_rgb", i), last_rgb, vecs[i].rgb);
            end
        end

        // Latency from lcd_wr pin rise to cmd_valid / frame_start
        @(negedge clk);
        lcd_d_c = 1'b0; lcd_rd = 1'b1; lcd_db = 8'h2C; lcd_wr = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr = 1'b1;
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (cmd_valid) begin
                hit = 1;
                chk("lat_frame_start", frame_start, 1);
            end
        end
        chk("lat_cycles", n, SYNC + 2);
        repeat (SYNC + 4) @(negedge clk);

        // resetN between hi and lo pixel bytes
        wr_byte(0, 1, 8'h2A); wr_byte(1, 1, 8'h00); wr_byte(1, 1, 8'h05);
        wr_byte(1, 1, 8'h00); wr_byte(1, 1, 8'h08);
        wr_byte(0, 1, 8'h2C); wr_byte(1, 1, 8'hAB); wr_byte(1, 1, 8'hCD);
        chk("rstmid_prev_x", pxl_x, 5);
        wr_byte(0, 1, 8'h2C); wr_byte(1, 1, 8'hF8);
        @(negedge clk); resetN = 1'b0;
        @(negedge clk);
        chk("rstmid_x_in_reset", pxl_x, 0);
        chk("rstmid_rgb_in_reset", pxl_rgb, 0);
        resetN = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        clr();
        wr_byte(1, 1, 8'h00);
        chk("rstmid_stray", n_pix, 0);
        wr_byte(0, 1, 8'h2C);
        wr_byte(1, 1, 8'h00);
        chk("rstmid_half", n_pix, 0);
        wr_byte(1, 1, 8'h1F);
        chk("rstmid_pix", n_pix, 1);
        chk("rstmid_x", last_x, 0);
        chk("rstmid_y", last_y, 0);
        chk("rstmid_rgb", last_rgb, m_rgb('h001F));

        // Randomized stream against the byte-level model
        pulse_reset();
        clr();
        model_reset();
        for (int op = 0; op < 60; op++) begin
            k = $urandom_range(0, 9);
            if (k <= 1) begin
                ax = $urandom_range(0, 1);
                s = $urandom_range(0, 8);
                e = s + $urandom_range(0, 4);
                if ($urandom_range(0, 5) == 0) e = (ax == 0 ? W : H) + $urandom_range(0, 3);
                if ($urandom_range(0, 5) == 0) begin e = s; s = s + 1; end
                send(0, 1, ax == 0 ? 'h2A : 'h2B);
                send(1, 1, s / 256); send(1, 1, s % 256);
                send(1, 1, e / 256); send(1, 1, e % 256);
            end else if (k <= 5) begin
                send(0, 1, 'h2C);
                np = $urandom_range(0, 7);
                for (int p = 0; p < np; p++) begin
                    send(1, 1, $urandom_range(0, 255));
                    send(1, 1, $urandom_range(0, 255));
                end
                if ($urandom_range(0, 3) == 0) send(1, 1, $urandom_range(0, 255));
            end else if (k == 6) begin
                send(0, 1, $urandom_range(0, 255));
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) send(1, 1, $urandom_range(0, 255));
            end else if (k == 7) begin
                send($urandom_range(0, 1), 0, $urandom_range(0, 255));
            end else begin
                send(1, 1, $urandom_range(0, 255));
            end
        end
        repeat (4) @(negedge clk);
        chk("rnd_cmd_count", got_cmd.size(), exp_cmd.size());
        chk("rnd_pix_count", got_pix.size(), exp_pix.size());
        chk("rnd_err_count", n_err, exp_err);
        chk("rnd_fs_count", n_fs, exp_fs);
        foreach (exp_cmd[i]) if (i < got_cmd.size()) chk($sformatf("rnd_cmd%0d", i), got_cmd[i], exp_cmd[i]);
        foreach (exp_pix[i]) if (i < got_pix.size()) chk($sformatf("rnd_pix%0d", i), got_pix[i], exp_pix[i]);

        // Panel reset held low: everything ignored, no errors
        lcd_reset = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        clr();
        wr_byte(0, 0, 8'h2C);
        wr_byte(0, 1, 8'h2A);
        chk("lcdrst_err", n_err, 0);
        chk("lcdrst_cmd", n_cmd, 0);
        lcd_reset = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        wr_byte(0, 1, 8'h2C); wr_byte(1, 1, 8'h07); wr_byte(1, 1, 8'hE0);
        chk("lcdrst_pix", n_pix, 1);
        chk("lcdrst_x", last_x, 0);
        chk("lcdrst_y", last_y, 0);
        chk("lcdrst_rgb", last_rgb, m_rgb('h07E0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
